// File: rtl/qoi_pkg.sv
// Shared constants, FSM state type and the QOI running-array hash.
package qoi_pkg;

  localparam logic [1:0] QOI_OP_INDEX    = 2'b00;
  localparam int         QOI_INDEX_DEPTH = 64;

  typedef enum logic {CLEAR, RUN} state_t;

  // The pixel is passed right-aligned in 32 bits. RGB pixels hash with an implicit alpha of 255.
  function automatic logic [5:0] qoi_hash(input logic [31:0] px, input int components);
    logic [12:0] r, g, b, a, sum;
    if (components == 4) begin
      r = 13'(px[31:24]);
      g = 13'(px[23:16]);
      b = 13'(px[15:8]);
      a = 13'(px[7:0]);
    end else begin
      r = 13'(px[23:16]);
      g = 13'(px[15:8]);
      b = 13'(px[7:0]);
      a = 13'd255;
    end
    sum = r * 13'd3 + g * 13'd5 + b * 13'd7 + a * 13'd11;
    return 6'(sum);
  endfunction

endpackage

// File: rtl/qoi_index_table.sv
// 64-entry running pixel array: the sweep-clear or update write port, and a combinational read that forwards a same-cycle update.
module qoi_index_table
  import qoi_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr_en,
  input  logic [5:0]   clr_addr,
  input  logic         wr_en,
  input  logic [5:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [5:0]   rd_addr,
  output logic [W-1:0] rd_data
);

  logic [W-1:0] mem [QOI_INDEX_DEPTH];

  // NOTE: the array has no reset branch; the parent's 64-cycle sweep zeroes it, so it maps to plain flops/RAM without a reset tree.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (wr_en && !clr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];

endmodule

// File: rtl/qoi_op_index_decoder.sv
// QOI_OP_INDEX chunk decoder: looks index bytes up in the running array and emits the pixel on a valid/ready port.
// Defining QOI_INDEX_STATS_EN adds the saturating hit_count and drop_count outputs.
module qoi_op_index_decoder
  import qoi_pkg::*;
#(
  parameter int COMPONENTS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              ibyte,
  input  logic                    ibyte_valid,
  output logic                    ibyte_ready,
  input  logic [8*COMPONENTS-1:0] upd_pixel,
  input  logic                    upd_valid,
  input  logic                    img_start,
  output logic [8*COMPONENTS-1:0] pixel,
  output logic                    pixel_valid,
  input  logic                    pixel_ready,
  output logic                    tag_err
`ifdef QOI_INDEX_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [15:0]             drop_count
`endif
);

  localparam int W = 8 * COMPONENTS;

  state_t       state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic         clr_en;
  logic         accept, is_index, wr_en;
  logic [5:0]   upd_hash;
  logic [W-1:0] rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every always_comb output is defaulted first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_en  = 1'b0;
    if (state_q == CLEAR) begin
      clr_en = 1'b1;
      cnt_d  = cnt_q + 6'd1;
      if (cnt_q == 6'd63) state_d = RUN;
    end
    if (img_start) begin
      state_d = CLEAR;
      cnt_d   = '0;
    end
  end

  assign ibyte_ready = (state_q == RUN) && (!pixel_valid || pixel_ready);
  assign accept      = ibyte_valid && ibyte_ready;
  assign is_index    = (ibyte[7:6] == QOI_OP_INDEX);
  assign wr_en       = upd_valid && (state_q == RUN);
  assign upd_hash    = qoi_hash(32'(upd_pixel), COMPONENTS);

  qoi_index_table #(.W(W)) u_table (
    .clk      (clk),
    .clr_en   (clr_en),
    .clr_addr (cnt_q),
    .wr_en    (wr_en),
    .wr_addr  (upd_hash),
    .wr_data  (upd_pixel),
    .rd_addr  (ibyte[5:0]),
    .rd_data  (rd_data)
  );

  // img_start wins over a same-cycle load so a restarted image never emits a stale pixel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pixel       <= '0;
      pixel_valid <= 1'b0;
      tag_err     <= 1'b0;
    end else begin
      tag_err <= accept && !is_index;
      if (img_start) begin
        pixel_valid <= 1'b0;
      end else if (accept && is_index) begin
        pixel       <= rd_data;
        pixel_valid <= 1'b1;
      end else if (pixel_ready) begin
        pixel_valid <= 1'b0;
      end
    end
  end

`ifdef QOI_INDEX_STATS_EN
  always_ff @(posedge clk) begin
    if (rst || img_start) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else begin
      if (pixel_valid && pixel_ready && (hit_count != '1)) hit_count <= hit_count + 32'd1;
      if (accept && !is_index && (drop_count != '1)) drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_qoi_op_index_decoder.sv
// Self-checking bench for qoi_op_index_decoder: spec vectors, hand sequences and a random run against a reference model.
module tb_qoi_op_index_decoder;

  localparam int COMPONENTS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  ibyte = '0;
  logic        ibyte_valid = 1'b0;
  logic        ibyte_ready;
  logic [31:0] upd_pixel = '0;
  logic        upd_valid = 1'b0;
  logic        img_start = 1'b0;
  logic [31:0] pixel;
  logic        pixel_valid;
  logic        pixel_ready = 1'b1;
  logic        tag_err;
`ifdef QOI_INDEX_STATS_EN
  logic [31:0] hit_count;
  logic [15:0] drop_count;
`endif

  qoi_op_index_decoder #(.COMPONENTS(COMPONENTS)) dut (
    .clk         (clk),
    .rst         (rst),
    .ibyte       (ibyte),
    .ibyte_valid (ibyte_valid),
    .ibyte_ready (ibyte_ready),
    .upd_pixel   (upd_pixel),
    .upd_valid   (upd_valid),
    .img_start   (img_start),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .tag_err     (tag_err)
`ifdef QOI_INDEX_STATS_EN
    ,
    .hit_count   (hit_count),
    .drop_count  (drop_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the array is zeroed at once on restart and simply stays unreadable for 64 cycles.
  logic [31:0] m_mem [64];
  logic [31:0] m_pixel;
  bit          m_valid, m_tag_err, m_run;
  int          m_clear_left;
  longint      m_hit, m_drop;

  function automatic int ref_hash(input logic [31:0] p);
    return (int'(p[31:24]) * 3 + int'(p[23:16]) * 5 + int'(p[15:8]) * 7 + int'(p[7:0]) * 11) % 64;
  endfunction

  task automatic m_restart();
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    m_run        = 1'b0;
    m_clear_left = 64;
    m_hit        = 0;
    m_drop       = 0;
  endtask

  // Called at a negedge with inputs already driven; advances one clock and compares against the model.
  task automatic tick();
    bit rdy, acc, bad;
    int idx;
    rdy = m_run && (!m_valid || pixel_ready);
    #1;
    check("ibyte_ready", 64'(ibyte_ready), 64'(rdy));
    acc = ibyte_valid && rdy;
    bad = acc && (ibyte[7:6] != 2'b00);
    idx = int'(ibyte[5:0]);
    if (rst) begin
      m_pixel = '0; m_valid = 0; m_tag_err = 0;
      m_restart();
    end else begin
      if (m_valid && pixel_ready && m_hit < 64'hFFFF_FFFF) m_hit++;
      if (bad && m_drop < 65535) m_drop++;
      if (img_start) begin
        m_valid = 0;
      end else if (acc && !bad) begin
        m_pixel = (m_run && upd_valid && ref_hash(upd_pixel) == idx) ? upd_pixel : m_mem[idx];
        m_valid = 1;
      end else if (pixel_ready) begin
        m_valid = 0;
      end
      m_tag_err = bad;
      if (m_run && upd_valid) m_mem[ref_hash(upd_pixel)] = upd_pixel;
      if (img_start) begin
        m_restart();
      end else if (!m_run) begin
        m_clear_left--;
        if (m_clear_left == 0) m_run = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("pixel_valid", 64'(pixel_valid), 64'(m_valid));
    check("pixel", 64'(pixel), 64'(m_pixel));
    check("tag_err", 64'(tag_err), 64'(m_tag_err));
`ifdef QOI_INDEX_STATS_EN
    check("hit_count", 64'(hit_count), 64'(m_hit));
    check("drop_count", 64'(drop_count), 64'(m_drop));
`endif
  endtask

  typedef struct {
    logic [7:0]  ibyte;
    logic        ibyte_valid;
    logic [31:0] upd_pixel;
    logic        upd_valid;
    logic        pixel_ready;
    logic        exp_valid;
    logic [31:0] exp_pixel;
    logic        exp_tag_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    // Spec vectors applied right after the first sweep (array all zero).
    vecs[0] = '{8'h05, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0};
    vecs[1] = '{8'h00, 1'b0, 32'h0A141EFF, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0};
    vecs[2] = '{8'h09, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0A141EFF, 1'b0};
    vecs[3] = '{8'h09, 1'b1, 32'h0A141EBF, 1'b1, 1'b1, 1'b1, 32'h0A141EBF, 1'b0};
    vecs[4] = '{8'hFE, 1'b1, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0A141EBF, 1'b1};
    vecs[5] = '{8'h00, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0A141EBF, 1'b0};
    vecs[6] = '{8'h05, 1'b1, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0,        1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ibyte_ready", 64'(ibyte_ready), 64'(0));
    check("rst_pixel_valid", 64'(pixel_valid), 64'(0));
    check("rst_pixel", 64'(pixel), 64'(0));
    check("rst_tag_err", 64'(tag_err), 64'(0));
    m_pixel = '0; m_valid = 0; m_tag_err = 0;
    m_restart();
    rst = 1'b0;

    // Byte held valid through the sweep: never ready for 64 cycles.
    ibyte = 8'h05; ibyte_valid = 1'b1;
    repeat (64) tick();
    check("ready_after_clear", 64'(ibyte_ready), 64'(1));

    for (int i = 0; i < 7; i++) begin
      ibyte = vecs[i].ibyte; ibyte_valid = vecs[i].ibyte_valid;
      upd_pixel = vecs[i].upd_pixel; upd_valid = vecs[i].upd_valid;
      pixel_ready = vecs[i].pixel_ready;
      tick();
      check($sformatf("vec%0d_valid", i), 64'(pixel_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d_pixel", i), 64'(pixel), 64'(vecs[i].exp_pixel));
      check($sformatf("vec%0d_tag_err", i), 64'(tag_err), 64'(vecs[i].exp_tag_err));
`ifdef QOI_INDEX_STATS_EN
      if (i == 4) check("drop_count_one", 64'(drop_count), 64'(1));
`endif
    end
    upd_valid = 1'b0;

    // Backpressure: output held for 5 cycles, then the waiting byte goes in on release.
    ibyte = 8'h09; ibyte_valid = 1'b1; pixel_ready = 1'b1;
    tick();
    ibyte = 8'h05; pixel_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_pixel", 64'(pixel), 64'(32'h0A141EBF));
      check("stall_valid", 64'(pixel_valid), 64'(1));
      check("stall_ready", 64'(ibyte_ready), 64'(0));
    end
    pixel_ready = 1'b1;
    tick();
    check("release_pixel", 64'(pixel), 64'(0));
    check("release_valid", 64'(pixel_valid), 64'(1));

    // Restart clears entry 9 and re-runs the 64-cycle sweep.
    ibyte_valid = 1'b0; img_start = 1'b1;
    tick();
    img_start = 1'b0;
    check("restart_valid", 64'(pixel_valid), 64'(0));
    ibyte = 8'h09; ibyte_valid = 1'b1;
    repeat (64) tick();
    tick();
    check("restart_pixel", 64'(pixel), 64'(0));
    check("restart_pixel_valid", 64'(pixel_valid), 64'(1));

    // Update and lookup of the same index in one cycle.
    upd_pixel = 32'h0A141EFF; upd_valid = 1'b1;
    tick();
    check("forward_pixel", 64'(pixel), 64'(32'h0A141EFF));
    upd_valid = 1'b0;

    // Random traffic, including occasional restarts.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] tag;
      tag = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ibyte       = {tag, 6'($urandom_range(0, 63))};
      ibyte_valid = ($urandom_range(0, 9) < 7);
      upd_pixel   = $urandom();
      upd_valid   = ($urandom_range(0, 1) == 1);
      pixel_ready = ($urandom_range(0, 9) < 7);
      img_start   = ($urandom_range(0, 399) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
